// File: rtl/thresh_event_pulser_pkg.sv
// thresh_event_pulser_pkg: shared FSM state encodings, timing-field width and default event-count width
package thresh_event_pulser_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PULSE = 2'd1, ST_REFRACT = 2'd2} state_t;
  localparam int TW = 8;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/thresh_event_pulser_if.sv
// thresh_event_pulser_if: bus bundle (master drives sample_CLK, thresh_in, enable, pulse_width, refractory, rate_window; slave drives dig_out, event_count, count_valid)
interface thresh_event_pulser_if #(parameter int NUM_CH = 2, parameter int CNT_W = 16);
  logic sample_CLK;
  logic [NUM_CH-1:0] thresh_in;
  logic [NUM_CH-1:0] enable;
  logic [7:0] pulse_width;
  logic [7:0] refractory;
  logic [15:0] rate_window;
  logic [NUM_CH-1:0] dig_out;
  logic [NUM_CH*CNT_W-1:0] event_count;
  logic count_valid;
  modport master(output sample_CLK, thresh_in, enable, pulse_width, refractory, rate_window, input dig_out, event_count, count_valid);
  modport slave(input sample_CLK, thresh_in, enable, pulse_width, refractory, rate_window, output dig_out, event_count, count_valid);
endinterface

// File: rtl/thresh_event_pulser_event_pulse_fsm.sv
// thresh_event_pulser_event_pulse_fsm: per-channel crossing-to-pulse FSM with refractory time and saturating window accumulator (in: dataclk, reset, tick, thresh_in, enable, pulse_width, refractory, win_on, win_pub; out: dig_out, acc)
module thresh_event_pulser_event_pulse_fsm
  import thresh_event_pulser_pkg::*;
#(parameter int CNT_W = CNT_W_DEF) (
  input  logic dataclk,
  input  logic reset,
  input  logic tick,
  input  logic thresh_in,
  input  logic enable,
  input  logic [TW-1:0] pulse_width,
  input  logic [TW-1:0] refractory,
  input  logic win_on,
  input  logic win_pub,
  output logic dig_out,
  output logic [CNT_W-1:0] acc
);
  state_t state, state_n;
  logic [TW-1:0] cnt, cnt_n;
  logic prev, accept, last;
  assign accept = enable & tick & thresh_in & ~prev & (state == ST_IDLE);
  assign last = cnt <= TW'(1);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (!enable) begin
      state_n = ST_IDLE;
      cnt_n = '0;
    end else if (accept) begin
      state_n = ST_PULSE;
      cnt_n = pulse_width == '0 ? TW'(1) : pulse_width;
    end else if (tick && state == ST_PULSE) begin
      state_n = !last ? ST_PULSE : refractory == '0 ? ST_IDLE : ST_REFRACT;
      cnt_n = !last ? cnt - 1'b1 : refractory;
    end else if (tick && state == ST_REFRACT) begin
      state_n = last ? ST_IDLE : ST_REFRACT;
      cnt_n = cnt - 1'b1;
    end
  end
  always_ff @(posedge dataclk or posedge reset)
    if (reset) begin
      state <= ST_IDLE;
      cnt <= '0;
      prev <= 1'b1;
      dig_out <= 1'b0;
      acc <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      dig_out <= state_n == ST_PULSE;
      if (tick) prev <= thresh_in;
      acc <= !win_on ? '0 : win_pub ? CNT_W'(accept) : (accept && ~&acc) ? acc + 1'b1 : acc;
    end
endmodule

// File: rtl/thresh_event_pulser.sv
// thresh_event_pulser: sample-tick generation, window counter and per-channel event pulsers (ports: dataclk, reset, bus.slave)
module thresh_event_pulser
  import thresh_event_pulser_pkg::*;
#(parameter int NUM_CH = 2, parameter int CNT_W = CNT_W_DEF) (
  input logic dataclk,
  input logic reset,
  thresh_event_pulser_if.slave bus
);
  logic sclk_d, tick, win_on, win_pub;
  logic [15:0] win_cnt;
  logic [NUM_CH*CNT_W-1:0] acc;
  assign tick = bus.sample_CLK & ~sclk_d;
  assign win_on = |bus.rate_window;
  assign win_pub = tick & win_on & (win_cnt >= bus.rate_window - 16'd1);
  always_ff @(posedge dataclk or posedge reset)
    if (reset) begin
      sclk_d <= 1'b0;
      win_cnt <= '0;
      bus.event_count <= '0;
      bus.count_valid <= 1'b0;
    end else begin
      sclk_d <= bus.sample_CLK;
      win_cnt <= (!win_on || win_pub) ? '0 : tick ? win_cnt + 1'b1 : win_cnt;
      bus.count_valid <= win_pub;
      if (win_pub) bus.event_count <= acc;
    end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    thresh_event_pulser_event_pulse_fsm #(.CNT_W(CNT_W)) u_event_pulse_fsm (
      .dataclk(dataclk),
      .reset(reset),
      .tick(tick),
      .thresh_in(bus.thresh_in[i]),
      .enable(bus.enable[i]),
      .pulse_width(bus.pulse_width),
      .refractory(bus.refractory),
      .win_on(win_on),
      .win_pub(win_pub),
      .dig_out(bus.dig_out[i]),
      .acc(acc[i*CNT_W +: CNT_W])
    );
  end
endmodule
